// File: rtl/reset_sequencer.sv
// Ordered reset release for N_DOMAINS reset domains: hold all, then release one by one with gap + ready ack.
// Optional ready-ack timeout enabled by defining RESET_SEQ_TIMEOUT_EN (default build: no timeout, timeout_err tied 0).
//
// state     | meaning
// ST_ASSERT | all domains held in reset, ctr counts down the hold time
// ST_WAIT   | domain idx released, waiting gap then domain_ready[idx]
// ST_DONE   | every domain released and acknowledged
module reset_sequencer #(
   parameter int N_DOMAINS     = 3,
   parameter int ASSERT_CYCLES = 16,
   parameter int GAP_CYCLES    = 8,
   parameter int TIMEOUT       = 1024,
   parameter int W_CTR         = $clog2(((((ASSERT_CYCLES > GAP_CYCLES) ? ASSERT_CYCLES : GAP_CYCLES) > TIMEOUT)
                                         ? ((ASSERT_CYCLES > GAP_CYCLES) ? ASSERT_CYCLES : GAP_CYCLES)
                                         : TIMEOUT) + 1)
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_force_rst,
   input  logic                 i_soft_rst_req,
   input  logic [N_DOMAINS-1:0] i_domain_ready,
   output logic [N_DOMAINS-1:0] o_domain_rst_n,
   output logic                 o_seq_busy,
   output logic                 o_seq_done,
   output logic                 o_timeout_err
);

   localparam int IDX_W = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;

   typedef enum logic [1:0] {
      ST_ASSERT = 2'd0,
      ST_WAIT   = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   state_t               r_state;
   logic [IDX_W-1:0]     r_idx;
   logic [W_CTR-1:0]     r_ctr;
   logic [N_DOMAINS-1:0] r_rst_n;
   logic                 r_busy;
   logic                 r_done;

   logic [IDX_W-1:0]     w_idx_nxt;
   logic                 w_ready;
   logic                 w_last;

   assign w_idx_nxt = r_idx + 1'b1;
   assign w_ready   = i_domain_ready[r_idx];
   assign w_last    = (r_idx == IDX_W'(N_DOMAINS - 1));

`ifdef RESET_SEQ_TIMEOUT_EN
   logic [W_CTR-1:0] r_tctr;
   logic             r_timeout_err;
   logic             w_tmo;

   assign w_tmo         = (r_tctr == W_CTR'(TIMEOUT - 1));
   assign o_timeout_err = r_timeout_err;
`else
   logic w_tmo;

   assign w_tmo         = 1'b0;
   assign o_timeout_err = 1'b0;
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst || i_force_rst || i_soft_rst_req) begin
         r_state <= ST_ASSERT;
         r_idx   <= '0;
         r_ctr   <= W_CTR'(ASSERT_CYCLES - 1);
         r_rst_n <= '0;
         r_busy  <= 1'b1;
         r_done  <= 1'b0;
`ifdef RESET_SEQ_TIMEOUT_EN
         r_tctr        <= '0;
         r_timeout_err <= 1'b0;
`endif
      end else begin
         case (r_state)
            ST_ASSERT: begin
               if (r_ctr == '0) begin
                  r_rst_n[0] <= 1'b1;
                  r_ctr      <= W_CTR'(GAP_CYCLES);
                  r_state    <= ST_WAIT;
`ifdef RESET_SEQ_TIMEOUT_EN
                  r_tctr     <= '0;
`endif
               end else begin
                  r_ctr <= r_ctr - 1'b1;
               end
            end
            ST_WAIT: begin
               if (r_ctr != '0) begin
                  r_ctr <= r_ctr - 1'b1;
               end else if (w_ready || w_tmo) begin
                  // A timeout advances the sequence exactly like a real ack, but flags it.
`ifdef RESET_SEQ_TIMEOUT_EN
                  if (!w_ready) r_timeout_err <= 1'b1;
                  r_tctr <= '0;
`endif
                  if (w_last) begin
                     r_state <= ST_DONE;
                     r_done  <= 1'b1;
                     r_busy  <= 1'b0;
                  end else begin
                     r_idx              <= w_idx_nxt;
                     r_rst_n[w_idx_nxt] <= 1'b1;
                     r_ctr              <= W_CTR'(GAP_CYCLES);
                  end
               end else begin
`ifdef RESET_SEQ_TIMEOUT_EN
                  r_tctr <= r_tctr + 1'b1;
`endif
               end
            end
            ST_DONE: begin
               r_done <= 1'b1;
               r_busy <= 1'b0;
            end
            default: begin
               r_state <= ST_ASSERT;
               r_ctr   <= W_CTR'(ASSERT_CYCLES - 1);
               r_rst_n <= '0;
               r_busy  <= 1'b1;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign o_domain_rst_n = r_rst_n;
   assign o_seq_busy     = r_busy;
   assign o_seq_done     = r_done;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer (N=3, ASSERT=16, GAP=8, TIMEOUT=32); release/done edges go through a scoreboard queue.
module tb_reset_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       force_rst = 1'b0;
   logic       soft_rst_req = 1'b0;
   logic [2:0] domain_ready = 3'b111;
   logic [2:0] domain_rst_n;
   logic       seq_busy;
   logic       seq_done;
   logic       timeout_err;

   int n_checks = 0;
   int n_err    = 0;
   int obs[4];

   typedef struct {
      string tag;
      int    exp;
   } sb_t;
   sb_t sb_q[$];

   reset_sequencer #(
      .N_DOMAINS    (3),
      .ASSERT_CYCLES(16),
      .GAP_CYCLES   (8),
      .TIMEOUT      (32)
   ) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_force_rst   (force_rst),
      .i_soft_rst_req(soft_rst_req),
      .i_domain_ready(domain_ready),
      .o_domain_rst_n(domain_rst_n),
      .o_seq_busy    (seq_busy),
      .o_seq_done    (seq_done),
      .o_timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input int observed, input int expected);
      n_checks++;
      assert (observed === expected)
      else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   task automatic push_seq(input string name, input int e0, input int e1, input int e2, input int ed);
      sb_q.push_back('{tag: {name, "_rel0"}, exp: e0});
      sb_q.push_back('{tag: {name, "_rel1"}, exp: e1});
      sb_q.push_back('{tag: {name, "_rel2"}, exp: e2});
      sb_q.push_back('{tag: {name, "_done"}, exp: ed});
   endtask

   // Steps max_edges edges, recording the first edge (1-based) each output rises; -1 if never.
   // At edge number set_edge, domain_ready is changed to set_val before that edge samples it.
   task automatic run(input int max_edges, input int set_edge, input logic [2:0] set_val);
      for (int i = 0; i < 4; i++) obs[i] = -1;
      for (int k = 1; k <= max_edges; k++) begin
         if (k == set_edge) domain_ready = set_val;
         step();
         for (int b = 0; b < 3; b++)
            if (obs[b] < 0 && domain_rst_n[b] === 1'b1) obs[b] = k;
         if (obs[3] < 0 && seq_done === 1'b1) obs[3] = k;
      end
   endtask

   task automatic drain_sb();
      for (int i = 0; i < 4; i++) begin
         sb_t e;
         if (sb_q.size() == 0) begin
            check("sb_underflow", 0, 1);
         end else begin
            e = sb_q.pop_front();
            check(e.tag, obs[i], e.exp);
         end
      end
   endtask

   task automatic soft_pulse();
      soft_rst_req = 1'b1;
      step();
      soft_rst_req = 1'b0;
   endtask

   initial begin
      int bad;

      // Test 1: power-on reset then straight sequence.
      repeat (4) step();
      check("rst_rst_n", int'(domain_rst_n), 0);
      check("rst_busy", int'(seq_busy), 1);
      check("rst_done", int'(seq_done), 0);
      check("rst_terr", int'(timeout_err), 0);
      rst = 1'b0;
      push_seq("t1", 16, 25, 34, 43);
      run(60, 0, 3'b111);
      drain_sb();
      check("t1_terr", int'(timeout_err), 0);
      check("t1_busy", int'(seq_busy), 0);

      // Dropping ready in DONE must not affect anything.
      domain_ready = 3'b000;
      repeat (5) step();
      check("done_hold_rst_n", int'(domain_rst_n), 7);
      check("done_hold_done", int'(seq_done), 1);
      domain_ready = 3'b111;

      // Test 3: soft reset from DONE restarts with identical spacing.
      soft_pulse();
      check("t3_rst_n", int'(domain_rst_n), 0);
      check("t3_done", int'(seq_done), 0);
      check("t3_busy", int'(seq_busy), 1);
      push_seq("t3", 16, 25, 34, 43);
      run(60, 0, 3'b111);
      drain_sb();

      // Test 2: ready[1] low until edge 60.
      domain_ready = 3'b101;
      soft_pulse();
      push_seq("t2", 16, 25, 60, 69);
      run(90, 60, 3'b111);
      drain_sb();
      check("t2_terr", int'(timeout_err), 0);

      // Test 4: force_rst for 50 cycles while waiting on domain 1.
      soft_pulse();
      run(20, 0, 3'b111);
      check("t4_pre_rst_n", int'(domain_rst_n), 1);
      force_rst = 1'b1;
      bad = 0;
      for (int k = 0; k < 50; k++) begin
         step();
         if (domain_rst_n !== 3'b000 || seq_busy !== 1'b1) bad++;
      end
      check("t4_held_cycles_bad", bad, 0);
      force_rst = 1'b0;
      push_seq("t4", 16, 25, 34, 43);
      run(60, 0, 3'b111);
      drain_sb();

      // Tests 5/6: ready[2] stuck low.
      domain_ready = 3'b011;
      soft_pulse();
`ifdef RESET_SEQ_TIMEOUT_EN
      push_seq("t5", 16, 25, 34, 74);
      run(120, 0, 3'b011);
      drain_sb();
      check("t5_terr", int'(timeout_err), 1);
      check("t5_busy", int'(seq_busy), 0);
      soft_pulse();
      check("t5_terr_cleared", int'(timeout_err), 0);
`else
      push_seq("t6", 16, 25, 34, -1);
      run(300, 0, 3'b011);
      drain_sb();
      check("t6_busy", int'(seq_busy), 1);
      check("t6_terr", int'(timeout_err), 0);
`endif

      // Reset mid-sequence drops every domain immediately.
      domain_ready = 3'b111;
      soft_pulse();
      run(30, 0, 3'b111);
      rst = 1'b1;
      step();
      check("midrst_rst_n", int'(domain_rst_n), 0);
      rst = 1'b0;
      push_seq("midrst", 16, 25, 34, 43);
      run(50, 0, 3'b111);
      drain_sb();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
